// File: rtl/axi_copy_master.sv
// axi_copy_master: single-command AXI copy engine. Each chunk is read into a
// local beat buffer with one read burst, then written back out with one
// write burst, then the write response is awaited before the next chunk.
// Chunks never exceed MAX_BURST beats and never cross a 4 KB page on either
// the source or the destination side.
module axi_copy_master #(
  parameter int MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         rst,
  // command side
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_src,
  input  logic [63:0]  cmd_dst,
  input  logic [15:0]  cmd_beats,
  output logic         busy,
  output logic         done,
  output logic         err,
  // write address
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [63:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  // write data
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  output logic [255:0] m_axi_wdata,
  output logic [31:0]  m_axi_wstrb,
  output logic         m_axi_wlast,
  // write response
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  // read address
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  output logic [63:0]  m_axi_araddr,
  output logic [7:0]   m_axi_arlen,
  output logic [2:0]   m_axi_arsize,
  // read data
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready,
  input  logic [255:0] m_axi_rdata,
  input  logic         m_axi_rlast
);

  // Buffer index width; a one-entry buffer still gets a 1-bit index.
  localparam int IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int BUF_D = 1 << IDX_W;
  localparam logic [8:0] MAX_N = 9'(MAX_BURST);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_AR   = 3'd2;
  localparam logic [2:0] ST_R    = 3'd3;
  localparam logic [2:0] ST_AW   = 3'd4;
  localparam logic [2:0] ST_W    = 3'd5;
  localparam logic [2:0] ST_B    = 3'd6;
  localparam logic [2:0] ST_DONE = 3'd7;

  logic [2:0]       state_r;
  logic [63:0]      src_r;
  logic [63:0]      dst_r;
  logic [15:0]      rem_r;
  logic [8:0]       n_r;
  logic [7:0]       len_r;
  logic [IDX_W-1:0] last_idx_r;
  logic [IDX_W-1:0] ridx_r;
  logic [IDX_W-1:0] widx_r;
  logic [255:0]     buf_r [0:BUF_D-1];

  logic [7:0]       src_room_s;
  logic [7:0]       dst_room_s;
  logic [8:0]       lim_a_s;
  logic [8:0]       lim_b_s;
  logic [8:0]       n_s;
  logic [7:0]       n_m1_s;
  logic [IDX_W-1:0] ridx_nxt_s;
  logic [IDX_W-1:0] widx_nxt_s;
  logic             misalign_s;

  // Beats left before each side hits the next 4 KB page (1..128, addresses are beat aligned).
  assign src_room_s = 8'd128 - {1'b0, src_r[11:5]};
  assign dst_room_s = 8'd128 - {1'b0, dst_r[11:5]};

  // Chunk size: smallest of the remaining beats, the buffer depth and both page rooms.
  assign lim_a_s = ({1'b0, src_room_s} < MAX_N) ? {1'b0, src_room_s} : MAX_N;
  assign lim_b_s = ({1'b0, dst_room_s} < lim_a_s) ? {1'b0, dst_room_s} : lim_a_s;
  assign n_s     = (rem_r < {7'd0, lim_b_s}) ? rem_r[8:0] : lim_b_s;
  assign n_m1_s  = 8'(n_s - 9'd1);

  assign ridx_nxt_s = ridx_r + IDX_W'(1);
  assign widx_nxt_s = widx_r + IDX_W'(1);
  assign misalign_s = (cmd_src[4:0] != 5'd0) || (cmd_dst[4:0] != 5'd0);

  // Fixed burst attributes: full 32-byte beats, all byte lanes written.
  assign m_axi_awsize = 3'd5;
  assign m_axi_arsize = 3'd5;
  assign m_axi_wstrb  = {32{1'b1}};
  assign m_axi_bready = (state_r == ST_B);

  // Capture read beats into the chunk buffer (contents need no reset).
  always_ff @(posedge clk) begin
    if ((state_r == ST_R) && m_axi_rvalid && m_axi_rready) begin
      buf_r[ridx_r] <= m_axi_rdata;
    end
  end

  // Copy sequencer: command intake, chunk sizing and the AXI channel handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      src_r         <= 64'd0;
      dst_r         <= 64'd0;
      rem_r         <= 16'd0;
      n_r           <= 9'd0;
      len_r         <= 8'd0;
      last_idx_r    <= '0;
      ridx_r        <= '0;
      widx_r        <= '0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= 64'd0;
      m_axi_arlen   <= 8'd0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= 64'd0;
      m_axi_awlen   <= 8'd0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= 256'd0;
      m_axi_wlast   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            src_r     <= cmd_src;
            dst_r     <= cmd_dst;
            rem_r     <= cmd_beats;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (misalign_s) begin
              err     <= 1'b1;
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else if (cmd_beats == 16'd0) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          n_r           <= n_s;
          len_r         <= n_m1_s;
          last_idx_r    <= n_m1_s[IDX_W-1:0];
          ridx_r        <= '0;
          m_axi_arvalid <= 1'b1;
          m_axi_araddr  <= src_r;
          m_axi_arlen   <= n_m1_s;
          state_r       <= ST_AR;
        end
        ST_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state_r       <= ST_R;
          end
        end
        ST_R: begin
          if (m_axi_rvalid) begin
            ridx_r <= ridx_nxt_s;
            if (ridx_r == last_idx_r) begin
              // Final expected beat: a missing rlast is an error, the data is still used.
              if (!m_axi_rlast) begin
                err <= 1'b1;
              end
              m_axi_rready  <= 1'b0;
              m_axi_awvalid <= 1'b1;
              m_axi_awaddr  <= dst_r;
              m_axi_awlen   <= len_r;
              state_r       <= ST_AW;
            end else if (m_axi_rlast) begin
              // Early rlast: flag it but keep collecting the full chunk.
              err <= 1'b1;
            end
          end
        end
        ST_AW: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            m_axi_wdata   <= buf_r[IDX_W'(0)];
            m_axi_wlast   <= (last_idx_r == IDX_W'(0));
            widx_r        <= '0;
            state_r       <= ST_W;
          end
        end
        ST_W: begin
          if (m_axi_wready) begin
            if (m_axi_wlast) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              state_r      <= ST_B;
            end else begin
              widx_r      <= widx_nxt_s;
              m_axi_wdata <= buf_r[widx_nxt_s];
              m_axi_wlast <= (widx_nxt_s == last_idx_r);
            end
          end
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            src_r <= src_r + {50'd0, n_r, 5'd0};
            dst_r <= dst_r + {50'd0, n_r, 5'd0};
            rem_r <= rem_r - {7'd0, n_r};
            if (rem_r == {7'd0, n_r}) begin
              done    <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end
        ST_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_copy_master.sv
// Bench for axi_copy_master: a behavioural AXI memory responder with optional
// random stalls, a burst-list reference model and directed/random copies.
module tb_axi_copy_master;

  localparam int MB = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_ready, busy, done, err;
  logic [63:0]  cmd_src, cmd_dst;
  logic [15:0]  cmd_beats;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, rlast;
  logic [63:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize;
  logic [255:0] wdata, rdata;
  logic [31:0]  wstrb;

  always #5 clk = ~clk;

  axi_copy_master #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_beats(cmd_beats), .busy(busy), .done(done), .err(err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rlast(rlast)
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
  } burst_t;

  int n_pass = 0;
  int n_total = 0;
  burst_t ar_log[$], aw_log[$], exp_ar[$], exp_aw[$], rd_jobs[$], wr_jobs[$];
  logic [255:0] mem [longint unsigned];
  bit stall_en, withhold_en;
  int wcount, done_cnt, arv_cnt, awv_cnt, rbeat, wbeat, b_pend;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Source data pattern, one 256-bit word per 32-byte beat address.
  function automatic logic [255:0] pat(input logic [63:0] w);
    logic [31:0] h;
    h = (w[31:0] ^ w[63:32]) * 32'h9E3779B1 ^ 32'h5A17C3E1;
    return {h, ~h, h + 32'd1, h ^ 32'hFFFF0000, h + 32'd7, ~h + 32'd3, h * 32'd3, h ^ 32'h0F0F0F0F};
  endfunction

  function automatic logic [255:0] memrd(input logic [63:0] w);
    return mem.exists(w) ? mem[w] : pat(w);
  endfunction

  // Reference: chunk list from the size rules (remaining, buffer depth, 4 KB pages).
  task automatic model_bursts(input logic [63:0] src, input logic [63:0] dst, input int beats);
    logic [63:0] s, d;
    int r, n, room;
    burst_t b;
    exp_ar.delete();
    exp_aw.delete();
    s = src; d = dst; r = beats;
    while (r > 0) begin
      n = (r < MB) ? r : MB;
      room = (4096 - int'(s[11:0])) / 32;
      if (room < n) n = room;
      room = (4096 - int'(d[11:0])) / 32;
      if (room < n) n = room;
      b.addr = s; b.len = 8'(n - 1); exp_ar.push_back(b);
      b.addr = d; exp_aw.push_back(b);
      s = s + 64'(n * 32);
      d = d + 64'(n * 32);
      r = r - n;
    end
  endtask

  // Memory responder: samples handshakes at negedge, updates state and drives at posedge+1.
  initial begin : responder
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic pw_ar, pw_aw, pw_w;
    logic [63:0] c_araddr, c_awaddr;
    logic [7:0] c_arlen, c_awlen;
    logic [255:0] c_wdata;
    logic c_wlast;
    burst_t b;
    logic [63:0] wa;
    pw_ar = 1'b0; pw_aw = 1'b0; pw_w = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
    rlast = 1'b0; rdata = 256'd0;
    rbeat = 0; wbeat = 0; b_pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_jobs.delete(); wr_jobs.delete();
        rbeat = 0; wbeat = 0; b_pend = 0;
        pw_ar = 1'b0; pw_aw = 1'b0; pw_w = 1'b0;
        ar_hs = 1'b0; aw_hs = 1'b0; w_hs = 1'b0; r_hs = 1'b0; b_hs = 1'b0;
      end else begin
        if (pw_ar) check("ar_hold", {arvalid, araddr, arlen}, {1'b1, c_araddr, c_arlen});
        if (pw_aw) check("aw_hold", {awvalid, awaddr, awlen}, {1'b1, c_awaddr, c_awlen});
        if (pw_w)  check("w_hold", {wvalid, wdata, wlast}, {1'b1, c_wdata, c_wlast});
        ar_hs = arvalid && arready; aw_hs = awvalid && awready; w_hs = wvalid && wready;
        r_hs = rvalid && rready; b_hs = bvalid && bready;
        pw_ar = arvalid && !arready; pw_aw = awvalid && !awready; pw_w = wvalid && !wready;
        c_araddr = araddr; c_arlen = arlen; c_awaddr = awaddr; c_awlen = awlen;
        c_wdata = wdata; c_wlast = wlast;
        if (done) done_cnt++;
        if (arvalid) arv_cnt++;
        if (awvalid) awv_cnt++;
      end
      @(posedge clk);
      #1;
      if (ar_hs) begin
        b.addr = c_araddr; b.len = c_arlen;
        rd_jobs.push_back(b); ar_log.push_back(b);
      end
      if (aw_hs) begin
        b.addr = c_awaddr; b.len = c_awlen;
        wr_jobs.push_back(b); aw_log.push_back(b);
      end
      if (w_hs) begin
        check("w_after_aw", 320'(wr_jobs.size() > 0), 320'(1));
        if (wr_jobs.size() > 0) begin
          wa = (wr_jobs[0].addr >> 5) + 64'(wbeat);
          mem[wa] = c_wdata;
          check("wlast", 320'(c_wlast), 320'(wbeat == int'(wr_jobs[0].len)));
          wcount++;
          if (wbeat == int'(wr_jobs[0].len)) begin
            void'(wr_jobs.pop_front());
            wbeat = 0;
            b_pend++;
          end else begin
            wbeat++;
          end
        end
      end
      if (r_hs && rd_jobs.size() > 0) begin
        if (rbeat == int'(rd_jobs[0].len)) begin
          void'(rd_jobs.pop_front());
          rbeat = 0;
        end else begin
          rbeat++;
        end
      end
      if (b_hs && b_pend > 0) b_pend--;
      arready = stall_en ? ($urandom % 3 != 0) : 1'b1;
      awready = stall_en ? ($urandom % 3 != 0) : 1'b1;
      wready  = stall_en ? ($urandom % 3 != 0) : 1'b1;
      if (rd_jobs.size() > 0) begin
        if (!(rvalid && !r_hs)) rvalid = stall_en ? ($urandom % 3 != 0) : 1'b1;
        rdata = memrd((rd_jobs[0].addr >> 5) + 64'(rbeat));
        rlast = (rbeat == int'(rd_jobs[0].len)) && !withhold_en;
      end else begin
        rvalid = 1'b0; rlast = 1'b0;
      end
      if (b_pend > 0) begin
        if (!(bvalid && !b_hs)) bvalid = stall_en ? ($urandom % 3 != 0) : 1'b1;
      end else begin
        bvalid = 1'b0;
      end
    end
  end

  task automatic run_copy(input logic [63:0] src, input logic [63:0] dst, input logic [15:0] beats,
                          input bit stall, input bit wh, input bit exp_err, input bit noise,
                          output int lat);
    int cyc, bad, nb;
    bit got, mis;
    mis = (src[4:0] != 5'd0) || (dst[4:0] != 5'd0);
    stall_en = stall;
    withhold_en = wh;
    model_bursts(src, dst, mis ? 0 : int'(beats));
    @(posedge clk);
    #1;
    ar_log.delete(); aw_log.delete();
    wcount = 0; done_cnt = 0; arv_cnt = 0; awv_cnt = 0;
    check("cmd_ready_idle", 320'(cmd_ready), 320'(1));
    cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_beats = beats;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 4000) begin
      if (done) begin
        got = 1'b1;
      end else begin
        cmd_valid = noise ? 1'($urandom % 2) : 1'b0;
        cmd_src = {$urandom, $urandom};
        cmd_dst = {$urandom, $urandom};
        cmd_beats = 16'($urandom);
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    cmd_valid = 1'b0;
    lat = cyc;
    check("done_seen", 320'(got), 320'(1));
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("done_once", 320'(done_cnt), 320'(1));
    check("idle_flags", {busy, cmd_ready, err}, {1'b0, 1'b1, exp_err});
    check("ar_count", 320'(ar_log.size()), 320'(exp_ar.size()));
    check("aw_count", 320'(aw_log.size()), 320'(exp_aw.size()));
    nb = (ar_log.size() < exp_ar.size()) ? ar_log.size() : exp_ar.size();
    for (int i = 0; i < nb; i++) check("ar_burst", {ar_log[i].addr, ar_log[i].len}, {exp_ar[i].addr, exp_ar[i].len});
    nb = (aw_log.size() < exp_aw.size()) ? aw_log.size() : exp_aw.size();
    for (int i = 0; i < nb; i++) check("aw_burst", {aw_log[i].addr, aw_log[i].len}, {exp_aw[i].addr, exp_aw[i].len});
    check("w_beats", 320'(wcount), 320'(mis ? 0 : int'(beats)));
    if (mis) begin
      check("no_axi_valid", 320'(arv_cnt + awv_cnt), 320'(0));
    end else begin
      bad = 0;
      for (int i = 0; i < int'(beats); i++)
        if (memrd((dst >> 5) + 64'(i)) !== pat((src >> 5) + 64'(i))) bad++;
      check("mem_copy", 320'(bad), 320'(0));
    end
  endtask

  initial begin : main
    int lat, cyc;
    logic [63:0] s, d;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_src = 64'd0; cmd_dst = 64'd0; cmd_beats = 16'd0;
    stall_en = 1'b0; withhold_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {cmd_ready, busy, done, err, arvalid, awvalid, wvalid, wlast, rready, bready},
          {1'b1, 9'b0});
    check("rst_payload", {araddr, awaddr, arlen, awlen}, {64'd0, 64'd0, 8'd0, 8'd0});
    check("rst_const", {awsize, arsize, wstrb}, {3'd5, 3'd5, 32'hFFFF_FFFF});
    rst = 1'b0;

    // basic copy
    run_copy(64'h1000, 64'h8000, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    if (ar_log.size() == 1) check("basic_ar", {ar_log[0].addr, ar_log[0].len}, {64'h1000, 8'd3});
    if (aw_log.size() == 1) check("basic_aw", {aw_log[0].addr, aw_log[0].len}, {64'h8000, 8'd3});

    // chunking 16,16,8
    run_copy(64'h2000, 64'h9000, 16'd40, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    if (ar_log.size() == 3) begin
      check("chunk_ar0", {ar_log[0].addr, ar_log[0].len}, {64'h2000, 8'd15});
      check("chunk_ar1", {ar_log[1].addr, ar_log[1].len}, {64'h2200, 8'd15});
      check("chunk_ar2", {ar_log[2].addr, ar_log[2].len}, {64'h2400, 8'd7});
    end

    // 4 KB split on the source side
    run_copy(64'h0FC0, 64'h20000, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    if (ar_log.size() == 2) begin
      check("split_ar0", {ar_log[0].addr, ar_log[0].len}, {64'h0FC0, 8'd1});
      check("split_ar1", {ar_log[1].addr, ar_log[1].len}, {64'h1000, 8'd1});
    end
    if (aw_log.size() == 2) check("split_aw1", aw_log[1].addr, 64'h20040);

    // misaligned source
    run_copy(64'h1004, 64'hA000, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, lat);
    check("err_latency", 320'(lat <= 2), 320'(1));

    // zero beats
    run_copy(64'h3000, 64'hB000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat);

    // rlast withheld, with stalls
    run_copy(64'h4000, 64'hC000, 16'd20, 1'b1, 1'b1, 1'b1, 1'b0, lat);

    // random copies with backpressure and ignored commands while busy
    for (int k = 0; k < 6; k++) begin
      s = 64'h10_0000 + 64'($urandom % 32768) * 64'd32;
      d = 64'h100_0000 + 64'(k) * 64'h10_0000 + 64'($urandom % 32768) * 64'd32;
      run_copy(s, d, 16'(1 + $urandom % 50), 1'b1, 1'b0, 1'b0, 1'b1, lat);
    end

    // reset during the second W beat
    stall_en = 1'b0; withhold_en = 1'b0;
    @(posedge clk);
    #1;
    wcount = 0;
    cmd_valid = 1'b1; cmd_src = 64'h6000; cmd_dst = 64'h300_0000; cmd_beats = 16'd8;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (wcount < 1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_w2", 320'(wcount), 320'(1));
    check("w2_active", 320'(wvalid), 320'(1));
    rst = 1'b1;
    #1;
    check("midrst_ctrl", {arvalid, awvalid, wvalid, rready, bready, busy, done, cmd_ready, wlast},
          {7'b0, 1'b1, 1'b0});
    check("midrst_payload", {awaddr, wdata}, {64'd0, 256'd0});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_copy(64'h7000, 64'h310_0000, 16'd20, 1'b1, 1'b0, 1'b0, 1'b1, lat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
